// File: rtl/gamepad_pkg.sv
// gamepad_pkg: shared FSM state type and pad-size constants for the gamepad poller.
package gamepad_pkg;
    typedef enum logic [2:0] {IDLE, LATCH, BIT_LOW, BIT_HIGH, DONE} state_t;
    localparam int NES_BUTTONS  = 8;
    localparam int SNES_BUTTONS = 12;
    localparam int MAX_PADS     = 4;
endpackage

// File: rtl/gamepad_tick.sv
// gamepad_tick: CLK_DIV cycle divider; tick marks the last cycle of each period.
module gamepad_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] r_cnt;
    assign tick = r_cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else     r_cnt <= (restart || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/gamepad_poller.sv
// gamepad_poller: drives latch/clock of NES/SNES shift-register pads and publishes
// button vectors, press edges and presence flags once per poll.
module gamepad_poller
    import gamepad_pkg::*;
#(
    parameter int NUM_PADS      = 2,
    parameter int NUM_BUTTONS   = SNES_BUTTONS,
    parameter int CLK_DIV       = 4,
    parameter int POLL_INTERVAL = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            auto_en,
    input  logic [NUM_PADS-1:0]             pad_data,
    output logic                            pad_latch,
    output logic                            pad_clk,
    output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
    output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed,
    output logic [NUM_PADS-1:0]             present,
    output logic                            valid,
    output logic                            busy
);
    localparam int BW = NUM_BUTTONS > 1 ? $clog2(NUM_BUTTONS) : 1;
    localparam int IW = $clog2(POLL_INTERVAL + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BUTTONS - 1);

    if (CLK_DIV < 4) begin : g_bad_div
        $error("gamepad_poller: CLK_DIV must be >= 4");
    end
    if (NUM_PADS < 1 || NUM_PADS > MAX_PADS) begin : g_bad_pads
        $error("gamepad_poller: NUM_PADS out of range");
    end

    state_t                          r_state;
    logic [BW-1:0]                   r_bit;
    logic                            r_half;
    logic [IW-1:0]                   r_ivl;
    logic [NUM_PADS-1:0]             r_sync1, r_sync2;
    logic                            w_tick, w_go, w_auto, w_sample;
    logic [NUM_PADS*NUM_BUTTONS-1:0] w_new, w_rise;
    logic [NUM_PADS-1:0]             w_present;

    gamepad_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk), .rst(rst), .restart(r_state == IDLE), .tick(w_tick)
    );

    assign w_auto   = r_state == IDLE && auto_en && r_ivl == IW'(POLL_INTERVAL - 1);
    assign w_go     = r_state == IDLE && (start || w_auto);
    assign w_sample = r_state == BIT_LOW && w_tick;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_ivl   <= '0;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;
            r_ivl   <= (r_state != IDLE || !auto_en || w_go) ? '0 : r_ivl + 1'b1;
        end

    // An all-ones shadow means every raw sample was low: the line is floating, no pad.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_BUTTONS-1:0] r_shadow;
        always_ff @(posedge clk or posedge rst)
            if (rst)           r_shadow <= '0;
            else if (w_sample) r_shadow[r_bit] <= ~r_sync2[p];
        assign w_present[p] = ~&r_shadow;
        assign w_new[p*NUM_BUTTONS +: NUM_BUTTONS]  = w_present[p] ? r_shadow : '0;
        assign w_rise[p*NUM_BUTTONS +: NUM_BUTTONS] = w_new[p*NUM_BUTTONS +: NUM_BUTTONS] &
                                                      ~buttons[p*NUM_BUTTONS +: NUM_BUTTONS];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= IDLE;
            r_bit     <= '0;
            r_half    <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            buttons   <= '0;
            pressed   <= '0;
            present   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid   <= 1'b0;
            pressed <= '0;
            case (r_state)
                IDLE: if (w_go) begin
                    r_state   <= LATCH;
                    r_bit     <= '0;
                    r_half    <= 1'b0;
                    pad_latch <= 1'b1;
                    busy      <= 1'b1;
                end
                LATCH: if (w_tick) begin
                    r_half <= ~r_half;
                    if (r_half) begin
                        r_state   <= BIT_LOW;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                    end
                end
                BIT_LOW: if (w_tick) begin
                    r_state <= BIT_HIGH;
                    pad_clk <= 1'b1;
                end
                BIT_HIGH: if (w_tick) begin
                    if (r_bit == LAST_BIT) begin
                        r_state <= DONE;
                        buttons <= w_new;
                        pressed <= w_rise;
                        present <= w_present;
                        valid   <= 1'b1;
                    end else begin
                        r_state <= BIT_LOW;
                        r_bit   <= r_bit + 1'b1;
                        pad_clk <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
endmodule
